instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 instr_fetch SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  16  byte address of the requested instruction, always even.
REQ-006 imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  16  fetched instruction word.
REQ-008 redirect  input  1  taken jal/jalr/beq/ble from the execute path (PCsrc != 00).
REQ-009 redirect_target  input  16  new PC on redirect.
REQ-010 inst_valid  output  1  inst, inst_pc and op hold a valid instruction.
REQ-011 inst_ready  input  1  decode/ControlUnit consumes the instruction.
REQ-012 inst  output  16  instruction at the head of the buffer.
REQ-013 inst_pc  output  16  address of inst.
REQ-014 op  output  4  inst[15:12], driven to ControlUnit.op.

Function
REQ-015 fetch_pc SHALL advance by 2 per accepted request, wrapping modulo 2^16 (0xFFFE -> 0x0000).
REQ-016 imem_req and imem_addr SHALL stay stable from assertion until the imem_ack cycle; at most one request is outstanding.
REQ-017 A new request SHALL be issued only when (buffer count + outstanding) < 2.
REQ-018 Acked data SHALL be written with its address into a 2-entry FIFO; inst_valid rises the cycle after imem_ack (1-cycle latency).
REQ-019 Pop SHALL occur on inst_valid && inst_ready; a simultaneous push and pop leaves the count unchanged.
REQ-020 The FSM SHALL have the states FETCH, WAIT, FULL and DROP.
REQ-021 FETCH: req asserted; on ack -> FETCH if space remains, else FULL.
REQ-022 WAIT: no request issued because the buffer lacks space; -> FETCH when space frees.
REQ-023 FULL: no request; -> FETCH when a pop occurs.
REQ-024 A redirect SHALL have priority over push and pop in the same cycle: the FIFO is cleared, fetch_pc <= {redirect_target[15:1],1'b0}, and inst_valid=0 next cycle.
REQ-025 If a request is outstanding without ack at redirect -> DROP: hold the old address until ack, discard that data, then -> FETCH at the target.
REQ-026 An ack coinciding with redirect SHALL be discarded; the next cycle requests the target.
REQ-027 A redirect while in DROP SHALL update the target only; the dropped response remains discarded.
REQ-028 With inst_valid=0, inst, inst_pc and op SHALL be 0.

Reset
REQ-029 While rst_n=0: fetch_pc=0x0000, imem_req=0, imem_addr=0x0000, inst_valid=0, inst=0, inst_pc=0, op=0, FIFO empty, state FETCH.
REQ-030 The first request (addr 0x0000) SHALL assert in the first clk edge after rst_n deasserts.
REQ-031 A reset mid-request SHALL abandon it; a later stray ack is not expected, and ack is ignored while rst_n=0.

Structure
REQ-032 A shared defines file SHALL hold the FSM state encodings, the PC reset vector (0x0000), the PC increment (2) and the op field slice [15:12].
REQ-033 The FIFO SHALL be a sub-module ifetch_fifo (2 entries, 32 bits = {pc, inst}, push/pop/clear, count output).

Verification
REQ-034 Reset release, ack every cycle, inst_ready=1 -> addresses 0x0000, 0x0002, 0x0004...; inst_valid from cycle 2 onward; op matches rdata[15:12].
REQ-035 inst_ready=0 for 6 cycles -> exactly 2 instructions buffered, imem_req=0 (FULL); a single pop re-issues a request at 0x0004.
REQ-036 Redirect to 0x0041 while a request at 0x0006 is unacked, ack after 3 cycles -> 0x0006 data never appears on inst, next request at 0x0040.
REQ-037 Redirect coinciding with ack and pop -> FIFO empty next cycle, next imem_addr = target.
REQ-038 Redirect to 0xFFFC -> fetches 0xFFFC, 0xFFFE, 0x0000 in order.
REQ-039 rst_n pulsed low mid-request with 1 entry buffered -> all outputs 0 immediately; refetch from 0x0000.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit definitions: FSM encodings, PC constants,
// opcode field position and the FIFO entry layout.
package instr_fetch_pkg;

  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'h0002;
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    FULL  = 2'b10,
    DROP  = 2'b11
  } if_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } if_entry_t;

  function automatic logic [3:0] op_of(input logic [15:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry {pc, inst} buffer between fetch and decode.
// Clear wins over push and pop in the same cycle.
module ifetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      clear_i,
  input  if_entry_t wdata_i,
  output if_entry_t rdata_o,
  output logic [1:0] count_o
);

  if_entry_t  mem_q [2];
  logic       wp_q;
  logic       rp_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata_i;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding request to imem, 2-deep
// buffer to decode, redirect with in-flight response dropping.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [3:0]  op
);

  if_state_e   state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drop_q, drop_d;
  logic        run_q;
  logic [1:0]  cnt;
  logic [1:0]  cnt_push;
  if_entry_t   head;
  if_entry_t   wentry;
  logic        push;
  logic        pop;
  logic        busy;

  // run_q keeps req low while in reset and for no longer
  assign imem_req  = run_q && ((state_q == FETCH) || (state_q == DROP));
  assign imem_addr = (state_q == DROP) ? drop_q : pc_q;
  assign busy      = imem_req && !imem_ack;

  assign inst_valid = (cnt != 2'd0);
  assign pop  = inst_valid && inst_ready && !redirect;
  assign push = imem_req && imem_ack && (state_q == FETCH) && !redirect;
  assign cnt_push = cnt + 2'd1 - {1'b0, pop};

  assign wentry.pc   = pc_q;
  assign wentry.inst = imem_rdata;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (push) pc_d = pc_q + PC_INC;
    if (redirect) pc_d = redirect_target & 16'hFFFE;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          if (busy) begin
            state_d = DROP;
            drop_d  = pc_q;
          end
        end else if (push) begin
          if (cnt_push == 2'd2) state_d = FULL;
        end else if (cnt == 2'd2) begin
          state_d = WAIT;
        end
      end
      WAIT, FULL: begin
        if (redirect || pop) state_d = FETCH;
      end
      DROP: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      drop_q  <= PC_RESET;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      run_q   <= 1'b1;
    end
  end

  ifetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (cnt)
  );

  assign inst    = inst_valid ? head.inst : 16'h0000;
  assign inst_pc = inst_valid ? head.pc : 16'h0000;
  assign op      = op_of(inst);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory returns ~addr as data.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [3:0]  op;
  logic        ack_en;

  int ncmp;
  int nerr;

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .op              (op)
  );

  assign imem_rdata = ~imem_addr;
  assign imem_ack   = ack_en & imem_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {15'd0, imem_req}, 16'h0);
    chk({tag, "_addr"}, imem_addr, 16'h0);
    chk({tag, "_vld"}, {15'd0, inst_valid}, 16'h0);
    chk({tag, "_inst"}, inst, 16'h0);
    chk({tag, "_pc"}, inst_pc, 16'h0);
    chk({tag, "_op"}, {12'd0, op}, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ncmp = 0;
    nerr = 0;
    rst_n = 1'b0;
    ack_en = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = 16'h0;
    tick;
    tick;
    chk_zero("rst");

    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick;
    chk("first_req", {15'd0, imem_req}, 16'h1);
    chk("first_addr", imem_addr, 16'h0000);
    chk("first_vld", {15'd0, inst_valid}, 16'h0);
    tick;
    chk("s1_vld", {15'd0, inst_valid}, 16'h1);
    chk("s1_pc", inst_pc, 16'h0000);
    chk("s1_inst", inst, 16'hFFFF);
    chk("s1_op", {12'd0, op}, 16'h000F);
    chk("s1_addr", imem_addr, 16'h0002);
    tick;
    chk("s2_pc", inst_pc, 16'h0002);
    chk("s2_inst", inst, 16'hFFFD);
    chk("s2_addr", imem_addr, 16'h0004);
    tick;
    chk("s3_pc", inst_pc, 16'h0004);
    chk("s3_addr", imem_addr, 16'h0006);

    inst_ready = 1'b0;
    tick;
    chk("full_req", {15'd0, imem_req}, 16'h0);
    repeat (5) tick;
    chk("full6_req", {15'd0, imem_req}, 16'h0);
    chk("full6_vld", {15'd0, inst_valid}, 16'h1);
    chk("full6_pc", inst_pc, 16'h0004);
    inst_ready = 1'b1;
    tick;
    chk("pop_pc", inst_pc, 16'h0006);
    chk("pop_inst", inst, 16'hFFF9);
    chk("pop_req", {15'd0, imem_req}, 16'h1);
    chk("pop_addr", imem_addr, 16'h0008);

    ack_en = 1'b0;
    tick;
    chk("empty_vld", {15'd0, inst_valid}, 16'h0);
    chk("empty_inst", inst, 16'h0);
    chk("empty_pc", inst_pc, 16'h0);
    chk("empty_op", {12'd0, op}, 16'h0);
    chk("empty_addr", imem_addr, 16'h0008);

    redirect = 1'b1;
    redirect_target = 16'h0041;
    tick;
    chk("drop_addr", imem_addr, 16'h0008);
    chk("drop_req", {15'd0, imem_req}, 16'h1);
    chk("drop_vld", {15'd0, inst_valid}, 16'h0);
    redirect_target = 16'h0101;
    tick;
    redirect = 1'b0;
    chk("drop2_addr", imem_addr, 16'h0008);
    ack_en = 1'b1;
    tick;
    chk("dropped_vld", {15'd0, inst_valid}, 16'h0);
    chk("dropped_addr", imem_addr, 16'h0100);
    chk("dropped_req", {15'd0, imem_req}, 16'h1);
    tick;
    chk("tgt_pc", inst_pc, 16'h0100);
    chk("tgt_inst", inst, 16'hFEFF);
    chk("tgt_op", {12'd0, op}, 16'h000F);
    chk("tgt_addr", imem_addr, 16'h0102);

    redirect = 1'b1;
    redirect_target = 16'hFFFD;
    tick;
    redirect = 1'b0;
    chk("coin_vld", {15'd0, inst_valid}, 16'h0);
    chk("coin_addr", imem_addr, 16'hFFFC);
    tick;
    chk("w0_pc", inst_pc, 16'hFFFC);
    chk("w0_inst", inst, 16'h0003);
    chk("w0_op", {12'd0, op}, 16'h0000);
    chk("w0_addr", imem_addr, 16'hFFFE);
    tick;
    chk("w1_pc", inst_pc, 16'hFFFE);
    chk("w1_inst", inst, 16'h0001);
    chk("w1_addr", imem_addr, 16'h0000);
    tick;
    chk("w2_pc", inst_pc, 16'h0000);
    chk("w2_inst", inst, 16'hFFFF);
    chk("w2_addr", imem_addr, 16'h0002);

    inst_ready = 1'b0;
    ack_en = 1'b0;
    tick;
    chk("pre_vld", {15'd0, inst_valid}, 16'h1);
    chk("pre_pc", inst_pc, 16'h0000);
    chk("pre_req", {15'd0, imem_req}, 16'h1);
    chk("pre_addr", imem_addr, 16'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    ack_en = 1'b1;
    tick;
    chk_zero("midrst2");
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick;
    chk("re_req", {15'd0, imem_req}, 16'h1);
    chk("re_addr", imem_addr, 16'h0000);
    chk("re_vld", {15'd0, inst_valid}, 16'h0);
    tick;
    chk("re1_vld", {15'd0, inst_valid}, 16'h1);
    chk("re1_pc", inst_pc, 16'h0000);
    chk("re1_addr", imem_addr, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
